// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state type, default
//   operand width and the bit-counter sizing helper.
package serial_adder_pkg;

    // Encodings match the original S_IDLE/S_RUN/S_DONE localparams so that
    // state values seen in older waveforms stay recognisable.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_e;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

    // Counter must hold 0..WIDTH, so WIDTH=1 still gets one bit.
    function automatic int unsigned sa_cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Single-bit combinational full adder cell used as the serial adder's
//   bit datapath.
//   Ports:
//     a, b, cin : operand bits and carry-in
//     sum       : a ^ b ^ cin
//     cout      : majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
//   then one bit per clock (LSB first) is pushed through a single full_adder
//   cell with a registered carry. Produces {cout, sum} = a + b + cin and a
//   one-cycle done strobe WIDTH cycles after start is accepted.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     start       : request, sampled only in IDLE or DONE
//     a, b, cin   : operands, captured when start is accepted
//     busy        : high while bits are being processed
//     done        : single-cycle completion strobe
//     sum, cout   : registered result, held until the next completion
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned   CW       = sa_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    sa_state_e        state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_shifted;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Shift-right with the new bit entering at the MSB, written as
    // shift/OR so it also elaborates cleanly for WIDTH=1.
    always_comb begin
        sum_shifted = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE, giving
            // back-to-back operation without an idle bubble.
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_shifted;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_ONE;
                // Last bit: publish the result including this cycle's bit.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_shifted;
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
